// File: rtl/uart_echo_top.sv
// uart_echo_top: 8N1 UART receiver that shows each good byte on the LEDs and echoes it back
module uart_echo_top #(
  parameter int         CLK_HZ       = 125_000_000,
  parameter int         BAUD         = 115_200,
  parameter int         CLKS_PER_BIT = CLK_HZ / BAUD,
  parameter logic [7:0] LED_IDLE     = 8'hF0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_rxd,
  output logic       uart_txd,
  output logic [7:0] led,
  input  logic       sw_1
);
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] MID  = CW'(CLKS_PER_BIT / 2 - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t rx_st_q, rx_st_d, tx_st_q, tx_st_d;
  logic meta_q, sync_q;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;
  logic [2:0] rx_bit_q, rx_bit_d, tx_bit_q, tx_bit_d;
  logic [7:0] rx_sh_q, rx_sh_d, tx_sh_q, tx_sh_d, led_q, led_d;
  logic txd_q, txd_d, rx_valid;
  logic unused;
  assign unused = sw_1;
  assign led = led_q;
  assign uart_txd = txd_q;
  // receiver: find the start edge, confirm it mid-bit, then sample each bit at its centre
  always_comb begin
    rx_st_d = rx_st_q;
    rx_cnt_d = rx_cnt_q + 1'b1;
    rx_bit_d = rx_bit_q;
    rx_sh_d = rx_sh_q;
    rx_valid = 1'b0;
    case (rx_st_q)
      IDLE: begin
        rx_cnt_d = '0;
        rx_st_d = sync_q ? IDLE : START;
      end
      START: if (rx_cnt_q == MID) begin
        rx_cnt_d = '0;
        rx_bit_d = '0;
        rx_st_d = sync_q ? IDLE : DATA;
      end
      DATA: if (rx_cnt_q == LAST) begin
        rx_cnt_d = '0;
        rx_sh_d = {sync_q, rx_sh_q[7:1]};
        rx_bit_d = rx_bit_q + 3'd1;
        rx_st_d = (rx_bit_q == 3'd7) ? STOP : DATA;
      end
      default: if (rx_cnt_q == LAST) begin
        rx_cnt_d = '0;
        rx_valid = sync_q;
        rx_st_d = IDLE;
      end
    endcase
  end
  // transmitter: takes a byte only when idle; txd is registered one cycle behind the state
  always_comb begin
    tx_st_d = tx_st_q;
    tx_cnt_d = tx_cnt_q + 1'b1;
    tx_bit_d = tx_bit_q;
    tx_sh_d = tx_sh_q;
    txd_d = (tx_st_q == START) ? 1'b0 : (tx_st_q == DATA) ? tx_sh_q[0] : 1'b1;
    led_d = rx_valid ? rx_sh_q : led_q;
    case (tx_st_q)
      IDLE: begin
        tx_cnt_d = '0;
        tx_sh_d = rx_valid ? rx_sh_q : tx_sh_q;
        tx_st_d = rx_valid ? START : IDLE;
      end
      START: if (tx_cnt_q == LAST) begin
        tx_cnt_d = '0;
        tx_bit_d = '0;
        tx_st_d = DATA;
      end
      DATA: if (tx_cnt_q == LAST) begin
        tx_cnt_d = '0;
        tx_sh_d = {1'b0, tx_sh_q[7:1]};
        tx_bit_d = tx_bit_q + 3'd1;
        tx_st_d = (tx_bit_q == 3'd7) ? STOP : DATA;
      end
      default: if (tx_cnt_q == LAST) begin
        tx_cnt_d = '0;
        tx_st_d = IDLE;
      end
    endcase
  end
  // state registers; reset drops any frame in flight and forces the line idle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      rx_st_q <= IDLE;
      rx_cnt_q <= '0;
      rx_bit_q <= '0;
      rx_sh_q <= '0;
      tx_st_q <= IDLE;
      tx_cnt_q <= '0;
      tx_bit_q <= '0;
      tx_sh_q <= '0;
      txd_q <= 1'b1;
      led_q <= LED_IDLE;
    end else begin
      meta_q <= uart_rxd;
      sync_q <= meta_q;
      rx_st_q <= rx_st_d;
      rx_cnt_q <= rx_cnt_d;
      rx_bit_q <= rx_bit_d;
      rx_sh_q <= rx_sh_d;
      tx_st_q <= tx_st_d;
      tx_cnt_q <= tx_cnt_d;
      tx_bit_q <= tx_bit_d;
      tx_sh_q <= tx_sh_d;
      txd_q <= txd_d;
      led_q <= led_d;
    end
  end
endmodule

// File: tb/tb_uart_echo_top.sv
// tb_uart_echo_top: randomized UART echo bench with a timing-level reference model
module tb_uart_echo_top;
  localparam int CPB = 100;
  localparam time TCLK = 8;
  logic clk = 0, reset = 0, uart_rxd = 1, sw_1 = 0;
  logic uart_txd;
  logic [7:0] led;
  int pass_n = 0, total_n = 0;
  logic [7:0] exp_led = 8'hF0;
  time tx_free = 0;
  logic [8:0] exp_q[$], echo_q[$];

  uart_echo_top #(.CLK_HZ(125_000_000), .BAUD(1_250_000)) dut (
    .clk(clk), .reset(reset), .uart_rxd(uart_rxd), .uart_txd(uart_txd), .led(led), .sw_1(sw_1)
  );

  initial forever #(TCLK / 2) clk = ~clk;
  initial forever begin #37; sw_1 = 1'($urandom_range(0, 1)); end

  // independent decoder of the echo line at the nominal bit rate
  initial forever begin
    logic [7:0] b;
    logic s;
    @(negedge uart_txd);
    repeat (CPB / 2) @(posedge clk);
    for (int i = 0; i < 8; i++) begin repeat (CPB) @(posedge clk); #1 b[i] = uart_txd; end
    repeat (CPB) @(posedge clk);
    #1 s = uart_txd;
    echo_q.push_back({s, b});
  end

  // model: a good byte lands on the LEDs ~9.5 bits after its start edge and is echoed only if the
  // previous echo (10 bits long) has finished by then
  task automatic predict(input logic [7:0] b, input logic stop);
    time tv;
    tv = $time + 953 * TCLK;
    if (stop) begin
      exp_led = b;
      if (tv >= tx_free) begin
        exp_q.push_back({1'b1, b});
        tx_free = tv + 1000 * TCLK;
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int bit_t, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin uart_rxd = f[i]; #(bit_t); end
    uart_rxd = 1'b1;
  endtask

  task automatic drain();
    repeat (12 * CPB) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 10; i++) begin
      #100;
      total_n++;
      if (led !== 8'hF0 || uart_txd !== 1'b1) $display("FAIL reset_hold led=%h txd=%b want f0/1", led, uart_txd);
      else pass_n++;
    end
    @(negedge clk) reset = 1'b1;
    #2000;
    total_n++;
    if (led !== 8'hF0 || uart_txd !== 1'b1) $display("FAIL reset_release led=%h txd=%b want f0/1", led, uart_txd);
    else pass_n++;
  endtask

  task automatic test_first();
    int lat = 0, low = 0;
    logic [8:0] e, g;
    @(posedge clk);
    #2;
    predict(8'h95, 1'b1);
    fork
      send_byte(8'h95, 792, 1'b1);
      begin
        while (led === 8'hF0 && lat < 2000) begin @(posedge clk); #1 lat++; end
      end
      begin
        for (int n = 0; n < 3000 && uart_txd; n++) begin @(posedge clk); #1; end
        while (!uart_txd && low < 2 * CPB) begin @(posedge clk); #1 low++; end
      end
    join
    total_n++;
    if (lat < 948 || lat > 956) $display("FAIL led_latency got %0d clocks want about 952", lat);
    else pass_n++;
    total_n++;
    if (low !== CPB) $display("FAIL echo_start_bit got %0d clocks want %0d", low, CPB);
    else pass_n++;
    total_n++;
    if (led !== exp_led) $display("FAIL first_led got %h want %h", led, exp_led);
    else pass_n++;
    drain();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = echo_q.size() ? echo_q.pop_front() : 9'h0;
      total_n++;
      if (g !== e) $display("FAIL first_echo got %h want %h", g, e);
      else pass_n++;
    end
    total_n++;
    if (echo_q.size() != 0) $display("FAIL first_echo_extra got %0d want 0", echo_q.size());
    else pass_n++;
    echo_q.delete();
  endtask

  task automatic test_sequence();
    logic [7:0] seq [2];
    logic [8:0] e, g;
    seq = '{8'hAA, 8'hFF};
    foreach (seq[i]) begin
      #1000;
      predict(seq[i], 1'b1);
      send_byte(seq[i], 800, 1'b1);
      total_n++;
      if (led !== exp_led) $display("FAIL seq_led got %h want %h", led, exp_led);
      else pass_n++;
    end
    drain();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = echo_q.size() ? echo_q.pop_front() : 9'h0;
      total_n++;
      if (g !== e) $display("FAIL seq_echo got %h want %h", g, e);
      else pass_n++;
    end
    total_n++;
    if (echo_q.size() != 0) $display("FAIL seq_echo_extra got %0d want 0", echo_q.size());
    else pass_n++;
    echo_q.delete();
  endtask

  task automatic test_back_to_back();
    logic [8:0] e, g;
    predict(8'h12, 1'b1);
    send_byte(8'h12, 784, 1'b1);
    total_n++;
    if (led !== exp_led) $display("FAIL b2b_led0 got %h want %h", led, exp_led);
    else pass_n++;
    predict(8'h34, 1'b1);
    send_byte(8'h34, 784, 1'b1);
    total_n++;
    if (led !== exp_led) $display("FAIL b2b_led1 got %h want %h", led, exp_led);
    else pass_n++;
    total_n++;
    if (exp_q.size() != 1) $display("FAIL b2b_model_drop got %0d queued want 1", exp_q.size());
    else pass_n++;
    drain();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = echo_q.size() ? echo_q.pop_front() : 9'h0;
      total_n++;
      if (g !== e) $display("FAIL b2b_echo got %h want %h", g, e);
      else pass_n++;
    end
    total_n++;
    if (echo_q.size() != 0) $display("FAIL b2b_echo_extra got %0d want 0", echo_q.size());
    else pass_n++;
    echo_q.delete();
  endtask

  task automatic test_framing();
    logic [8:0] e, g;
    predict(8'h66, 1'b0);
    send_byte(8'h66, 784, 1'b0);
    #1000;
    total_n++;
    if (led !== exp_led) $display("FAIL framing_led got %h want %h", led, exp_led);
    else pass_n++;
    predict(8'h3C, 1'b1);
    send_byte(8'h3C, 800, 1'b1);
    total_n++;
    if (led !== 8'h3C) $display("FAIL framing_next_led got %h want 3c", led);
    else pass_n++;
    drain();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = echo_q.size() ? echo_q.pop_front() : 9'h0;
      total_n++;
      if (g !== e) $display("FAIL framing_echo got %h want %h", g, e);
      else pass_n++;
    end
    total_n++;
    if (echo_q.size() != 0) $display("FAIL framing_echo_extra got %0d want 0", echo_q.size());
    else pass_n++;
    echo_q.delete();
  endtask

  task automatic test_glitch();
    uart_rxd = 1'b0;
    #200;
    uart_rxd = 1'b1;
    drain();
    total_n++;
    if (led !== exp_led || uart_txd !== 1'b1) $display("FAIL glitch led=%h txd=%b want %h/1", led, uart_txd, exp_led);
    else pass_n++;
    total_n++;
    if (echo_q.size() != 0) $display("FAIL glitch_echo got %0d frames want 0", echo_q.size());
    else pass_n++;
    echo_q.delete();
  endtask

  task automatic test_reset_mid();
    logic [8:0] e, g;
    predict(8'h5A, 1'b1);
    send_byte(8'h5A, 800, 1'b1);
    total_n++;
    if (led !== 8'h5A) $display("FAIL pre_reset_led got %h want 5a", led);
    else pass_n++;
    fork
      send_byte(8'hC3, 800, 1'b1);
      begin
        #(3 * 800);
        reset = 1'b0;
        #1;
        total_n++;
        if (led !== 8'hF0 || uart_txd !== 1'b1) $display("FAIL mid_reset led=%h txd=%b want f0/1", led, uart_txd);
        else pass_n++;
      end
    join
    #100;
    total_n++;
    if (led !== 8'hF0 || uart_txd !== 1'b1) $display("FAIL mid_reset_hold led=%h txd=%b want f0/1", led, uart_txd);
    else pass_n++;
    reset = 1'b1;
    exp_led = 8'hF0;
    tx_free = 0;
    exp_q.delete();
    drain();
    echo_q.delete();
    total_n++;
    if (led !== 8'hF0 || uart_txd !== 1'b1) $display("FAIL post_reset led=%h txd=%b want f0/1", led, uart_txd);
    else pass_n++;
    predict(8'h81, 1'b1);
    send_byte(8'h81, 808, 1'b1);
    total_n++;
    if (led !== 8'h81) $display("FAIL post_reset_led got %h want 81", led);
    else pass_n++;
    drain();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = echo_q.size() ? echo_q.pop_front() : 9'h0;
      total_n++;
      if (g !== e) $display("FAIL post_reset_echo got %h want %h", g, e);
      else pass_n++;
    end
    total_n++;
    if (echo_q.size() != 0) $display("FAIL post_reset_echo_extra got %0d want 0", echo_q.size());
    else pass_n++;
    echo_q.delete();
  endtask

  task automatic test_random();
    logic [8:0] e, g;
    logic [7:0] b;
    int bit_t, gap;
    time tv;
    for (int k = 0; k < 6; k++) begin
      b = 8'($urandom);
      bit_t = int'($urandom_range(784, 816));
      gap = int'($urandom_range(0, 2400));
      tv = $time + time'(gap) + 953 * TCLK;
      if ((tv > tx_free ? tv - tx_free : tx_free - tv) < 100) gap += 200;
      #(gap);
      predict(b, 1'b1);
      send_byte(b, bit_t, 1'b1);
      total_n++;
      if (led !== exp_led) $display("FAIL rand_led got %h want %h", led, exp_led);
      else pass_n++;
    end
    drain();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = echo_q.size() ? echo_q.pop_front() : 9'h0;
      total_n++;
      if (g !== e) $display("FAIL rand_echo got %h want %h", g, e);
      else pass_n++;
    end
    total_n++;
    if (echo_q.size() != 0) $display("FAIL rand_echo_extra got %0d want 0", echo_q.size());
    else pass_n++;
    echo_q.delete();
  endtask

  initial begin
    test_reset();
    test_first();
    test_sequence();
    test_back_to_back();
    test_framing();
    test_glitch();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule

// File: doc/uart_echo_top.md
Name: uart_echo_top

Overview:
- Top-level UART block: 8N1 receiver plus transmitter.
- Each correctly framed byte received on uart_rxd is shown on the 8-bit led bus and echoed back on uart_txd.
- Sits directly at the board pins (serial RX/TX, LEDs, one switch).
- Idle/reset LED pattern is 8'hF0, so "no byte yet" is distinguishable.

Parameters:
- CLK_HZ, 125000000, system clock frequency in Hz.
- BAUD, 115200, serial bit rate.
- CLKS_PER_BIT, CLK_HZ/BAUD (=1085), clocks per serial bit (integer division, derived).
- LED_IDLE, 8'hF0, led value after reset, until the first valid byte.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- uart_rxd  input  1  serial in; idle high; 8N1, LSB first.
- uart_txd  output  1  serial out; idle high; 8N1, LSB first.
- led  output  8  last valid received byte; LED_IDLE after reset.
- sw_1  input  1  reserved; ignored by logic (may float, must not affect any output).

Behaviour:
- Reset asserted (reset=0): led=LED_IDLE, uart_txd=1, RX and TX FSMs to IDLE, all counters 0. Takes effect immediately; may occur mid-frame; the partial frame is discarded.
- RX sync: uart_rxd passes through a 2-flop synchronizer; reset value 1.
- RX FSM states: IDLE, START, DATA, STOP.
  - IDLE: on synchronized 0, go to START and clear the counter.
  - START: at CLKS_PER_BIT/2 clocks, resample. If 1 (glitch), return to IDLE. If 0, go to DATA.
  - DATA: sample once every CLKS_PER_BIT clocks (mid-bit), 8 samples, shifted in LSB first.
  - STOP: sample after CLKS_PER_BIT clocks. If 1, raise rx_valid for exactly one cycle. If 0 (framing error), drop the byte with no pulse. Either way, return to IDLE.
  - Must tolerate ±2% baud mismatch (e.g. 8600 ns bit period against 125 MHz clock).
- On rx_valid: led <= received byte on the same clock edge. led holds until the next valid byte.
- Echo:
  - On rx_valid with the TX FSM in IDLE, the byte is loaded into TX and transmission starts on the next cycle.
  - If TX is busy, the byte is not echoed (dropped for TX only); led still updates.
- TX FSM states: IDLE, START, DATA, STOP.
  - Frame: start bit 0, 8 data bits LSB first, stop bit 1.
  - Each bit is held exactly CLKS_PER_BIT clocks; total frame is 10*CLKS_PER_BIT clocks.
  - Returns to IDLE after the stop bit; uart_txd is 1 in IDLE.
  - Internal tx_busy is high from load until the end of the stop bit.
- RX and TX run independently (full duplex). A new byte may arrive while the echo is in progress.
- Latency:
  - led updates about (9.5*CLKS_PER_BIT + 2) clocks after the falling edge of the start bit.
  - Echo start bit begins 1 cycle after the led update.
- Outputs are registered; no combinational path from uart_rxd to any output.
- Counter widths are sized from CLKS_PER_BIT (≥11 bits at the defaults).

Test Plan:
- Reset held 1 µs, rxd=1: led=8'hF0 and txd=1 throughout reset and after release; no change without stimulus.
- Release reset; send 0x95 at 8600 ns/bit: led becomes 8'h95 shortly after the stop-bit midpoint; txd echoes frame 0 1010 1001 1 (LSB first) at 1085 clk/bit.
- 1 µs after the first frame ends, send 0xAA, then 1 µs later 0xFF: led steps 0x95→0xAA→0xFF. Each byte is echoed when TX is idle at rx_valid; a byte arriving while TX is busy updates led only.
- Frame with stop bit 0: led unchanged, no echo; a following good frame (0x3C) is received correctly.
- 200 ns low glitch on rxd while idle: rejected at the mid-start check; led/txd unchanged.
- Assert reset mid-RX-frame and mid-TX-frame: led returns to 8'hF0, txd goes to 1 immediately, and the next full frame is received normally.
